// File: rtl/uart_alu_ctrl.sv
// uart_alu_ctrl: collects operand A, operand B and opcode bytes, drives the ALU and sends the result to uart_tx.
// Define UART_CTRL_STATUS_EN to also send a {carry, zero} status byte after each result byte.
module uart_alu_ctrl #(
    parameter int NB_DATA     = 8,
    parameter int NB_OP       = 6,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rx_done_tick,
    input  logic [NB_DATA-1:0] rx_data,
    input  logic               tx_done_tick,
    input  logic [NB_DATA-1:0] alu_result,
    input  logic               alu_zero,
    input  logic               alu_carry,
    output logic [NB_DATA-1:0] alu_a,
    output logic [NB_DATA-1:0] alu_b,
    output logic [NB_OP-1:0]   alu_op,
    output logic               tx_start,
    output logic [NB_DATA-1:0] tx_data,
    output logic               busy,
    output logic               err_timeout,
    output logic               rx_overrun
);
    localparam int NB_CNT = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    typedef enum logic [2:0] {WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX, SEND_ST, WAIT_ST} state_t;
    state_t            r_state, w_next;
    logic [NB_CNT-1:0] r_cnt;
    logic              w_collect, w_timeout;
    assign w_collect = (r_state == WAIT_B) || (r_state == WAIT_OP);
    assign w_timeout = (TIMEOUT_CYC != 0) && w_collect && !rx_done_tick && (r_cnt == CNT_LAST);
    assign tx_start  = (r_state == SEND) || (r_state == SEND_ST);
    assign busy      = r_state != WAIT_A;
`ifdef UART_CTRL_STATUS_EN
    logic [1:0] r_status;
    always_ff @(posedge clk)
        if (reset) r_status <= '0;
        else if (r_state == EXEC) r_status <= {alu_carry, alu_zero};
`else
    logic w_unused_flags;
    assign w_unused_flags = alu_zero ^ alu_carry;
`endif
    always_comb begin
        w_next = r_state;
        case (r_state)
            WAIT_A:  w_next = rx_done_tick ? WAIT_B : WAIT_A;
            WAIT_B:  w_next = rx_done_tick ? WAIT_OP : w_timeout ? WAIT_A : WAIT_B;
            WAIT_OP: w_next = rx_done_tick ? EXEC : w_timeout ? WAIT_A : WAIT_OP;
            EXEC:    w_next = SEND;
            SEND:    w_next = WAIT_TX;
`ifdef UART_CTRL_STATUS_EN
            WAIT_TX: w_next = tx_done_tick ? SEND_ST : WAIT_TX;
            SEND_ST: w_next = WAIT_ST;
            WAIT_ST: w_next = tx_done_tick ? WAIT_A : WAIT_ST;
`else
            WAIT_TX: w_next = tx_done_tick ? WAIT_A : WAIT_TX;
`endif
            default: w_next = WAIT_A;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= WAIT_A;
            r_cnt       <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= '0;
            tx_data     <= '0;
            err_timeout <= 1'b0;
            rx_overrun  <= 1'b0;
        end else begin
            r_state     <= w_next;
            // counter saturates so a disabled timeout never wraps
            r_cnt       <= (!w_collect || rx_done_tick) ? '0 : (&r_cnt) ? r_cnt : r_cnt + NB_CNT'(1);
            err_timeout <= w_timeout;
            rx_overrun  <= rx_done_tick && busy && !w_collect;
            if (rx_done_tick && r_state == WAIT_A) alu_a <= rx_data;
            if (rx_done_tick && r_state == WAIT_B) alu_b <= rx_data;
            if (rx_done_tick && r_state == WAIT_OP) alu_op <= rx_data[NB_OP-1:0];
            if (r_state == EXEC) tx_data <= alu_result;
`ifdef UART_CTRL_STATUS_EN
            if (r_state == WAIT_TX && tx_done_tick) tx_data <= {{(NB_DATA-2){1'b0}}, r_status};
`endif
        end
    end
endmodule

// File: doc/uart_alu_ctrl.md
Name: uart_alu_ctrl

Overview:
Sequencer between uart_rx, uart_tx and the combinational ALU in the TP2 UART-ALU datapath. It collects three received bytes in order (operand A, operand B, opcode) and drives them to the ALU. It then captures the result and hands it to the transmitter with a one-cycle start pulse. An inter-byte timeout discards partial frames; late bytes are flagged as overrun.

Parameters:
NB_DATA, 8, width of UART bytes, ALU operands and ALU result
NB_OP, 6, opcode width; taken from rx_data[NB_OP-1:0]
TIMEOUT_CYC, 1000000, clk cycles allowed between frame bytes; 0 disables the timeout

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
rx_done_tick  in  1  one-cycle pulse from uart_rx; rx_data valid in the same cycle
rx_data  in  NB_DATA  received byte
tx_done_tick  in  1  one-cycle pulse from uart_tx, end of stop bit
alu_result  in  NB_DATA  combinational ALU output
alu_zero  in  1  ALU zero flag; used only with feature
alu_carry  in  1  ALU carry flag; used only with feature
alu_a  out  NB_DATA  operand A, registered
alu_b  out  NB_DATA  operand B, registered
alu_op  out  NB_OP  opcode, registered
tx_start  out  1  one-cycle start pulse to uart_tx
tx_data  out  NB_DATA  byte to transmit, registered
busy  out  1  high whenever state != WAIT_A
err_timeout  out  1  one-cycle pulse: partial frame discarded
rx_overrun  out  1  one-cycle pulse: byte received while not accepting

Behaviour:
- Reset values: state=WAIT_A, timeout counter=0, and every output is 0 (alu_a, alu_b, alu_op, tx_data, tx_start, err_timeout, rx_overrun, busy).
- WAIT_A: on rx_done_tick, alu_a<=rx_data, counter<=0, go to WAIT_B.
- WAIT_B: on rx_done_tick, alu_b<=rx_data, counter<=0, go to WAIT_OP.
- WAIT_OP: on rx_done_tick, alu_op<=rx_data[NB_OP-1:0], go to EXEC.
- In WAIT_B and WAIT_OP, the counter increments each cycle. Its first cycle in the state is 0.
- Timeout: counter==TIMEOUT_CYC-1 with no rx_done_tick causes a move to WAIT_A. err_timeout=1 in the next cycle. alu_a, alu_b and alu_op keep their old values.
- If a byte and the timeout occur in the same cycle, the byte wins.
- The counter width is $clog2(TIMEOUT_CYC+1) and it never wraps.
- EXEC: one cycle. tx_data<=alu_result, then go to SEND.
- SEND: tx_start=1 for exactly this cycle, then go to WAIT_TX.
- Latency: opcode rx_done_tick in cycle t gives alu_op valid at t+1, tx_start high at t+2, and tx_data valid from t+2.
- WAIT_TX: on tx_done_tick, go to WAIT_A. There is no timeout in this state.
- rx_done_tick in EXEC, SEND or WAIT_TX is dropped and rx_overrun=1 in the next cycle. No state, operand or tx_data changes.
- tx_done_tick outside WAIT_TX is ignored.
- alu_a, alu_b, alu_op and tx_data hold until reloaded.
- tx_start is never high for two consecutive cycles.
- Reset mid-frame or mid-transmit returns to reset values on the next edge. No tx_start is issued.

Optional Feature:
UART_CTRL_STATUS_EN
- Defined: EXEC also latches {alu_carry, alu_zero} into a status register. After the result byte's tx_done_tick, go to SEND_ST instead of WAIT_A. SEND_ST drives tx_data = {{(NB_DATA-2){1'b0}}, carry, zero} with tx_start=1 for one cycle, then goes to WAIT_ST. WAIT_ST waits for tx_done_tick, then goes to WAIT_A. Overrun rules cover SEND_ST and WAIT_ST.
- Undefined: one byte per frame; alu_zero and alu_carry are unused.

Test Plan:
- ADD: bytes 0x05, 0x03, 0x20 with alu_result modelled as 0x08 -> alu_a=0x05, alu_b=0x03, alu_op=0x20; a single tx_start two cycles after the opcode tick; tx_data=0x08; busy drops the cycle after tx_done_tick.
- Timeout (TIMEOUT_CYC=100): send 0x11, then idle -> err_timeout pulses 101 cycles after the A tick. Next bytes 0x22, 0x33, 0x24 form a fresh frame with alu_a=0x22.
- Overrun: send byte 0x7F while in WAIT_TX -> rx_overrun pulses once; alu_a, alu_b, alu_op and tx_data are unchanged; the next frame works normally.
- Reset mid-frame: after 0x05 and 0x03, assert reset for one cycle -> all outputs 0, state WAIT_A; no tx_start is seen.
- Collision: rx_done_tick in the exact timeout-expiry cycle -> byte accepted, no err_timeout.
- UART_CTRL_STATUS_EN: 0xFF, 0x01, ADD with result 0x00, zero=1, carry=1 -> two tx_start pulses, with tx_data 0x00 then 0x03.
